melody_sequencer: RTL and testbench

//   Upstream stage of buzzer_control: steps through a fixed 8-entry note table and

---
 rtl/melody_sequencer.sv | 142 ++++++++++++++
 tb/tb_melody_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// melody_sequencer - steps an 8-entry note table and drives a tone divider with beat timing and articulation gaps.
module melody_sequencer #(
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int LOOP        = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play,
  input  logic        restart,
  output logic [19:0] note_div,
  output logic [2:0]  song_idx,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(3 * BEAT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

  state_t          state, state_nx;
  logic [2:0]      idx, idx_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            hold, hold_nx;
  logic            done_nx;
  logic [19:0]     note_nx;
  logic [CW-1:0]   note_last;
  logic [CW-1:0]   gap_last;

  function automatic logic [19:0] tone(input logic [2:0] i);
    case (i)
      3'd0:    tone = 20'd191571;
      3'd1:    tone = 20'd170648;
      3'd2:    tone = 20'd151515;
      3'd3:    tone = 20'd143266;
      3'd4:    tone = 20'd127551;
      3'd5:    tone = 20'd113636;
      3'd6:    tone = 20'd0;
      default: tone = 20'd95420;
    endcase
  endfunction

  function automatic int beats(input logic [2:0] i);
    case (i)
      3'd4, 3'd5: beats = 2;
      3'd7:       beats = 3;
      default:    beats = 1;
    endcase
  endfunction

  assign note_last = CW'(beats(idx) * BEAT_CYCLES - GAP_CYCLES - 1);
  assign gap_last  = CW'(GAP_CYCLES - 1);

  // hold keeps a finished non-looping song from relaunching while play stays high;
  // play must drop (or restart pulse) before the next run.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    hold_nx  = hold;
    done_nx  = 1'b0;
    if (restart) begin
      idx_nx   = 3'd0;
      cnt_nx   = '0;
      hold_nx  = 1'b0;
      state_nx = play ? NOTE : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!play) begin
            hold_nx = 1'b0;
          end else if (!hold) begin
            state_nx = NOTE;
            idx_nx   = 3'd0;
            cnt_nx   = '0;
          end
        end
        NOTE: begin
          if (play) begin
            if (cnt == note_last) begin
              state_nx = GAP;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (play) begin
            if (cnt == gap_last) begin
              cnt_nx = '0;
              if (idx == 3'd7) begin
                idx_nx = 3'd0;
                if (LOOP != 0) begin
                  state_nx = NOTE;
                end else begin
                  state_nx = IDLE;
                  done_nx  = 1'b1;
                  hold_nx  = 1'b1;
                end
              end else begin
                idx_nx   = idx + 3'd1;
                state_nx = NOTE;
              end
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
        default: begin
          state_nx = IDLE;
          idx_nx   = 3'd0;
          cnt_nx   = '0;
        end
      endcase
    end
    note_nx = (state_nx == NOTE && play) ? tone(idx_nx) : 20'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 3'd0;
      cnt      <= '0;
      hold     <= 1'b0;
      note_div <= 20'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      cnt      <= cnt_nx;
      hold     <= hold_nx;
      note_div <= note_nx;
      busy     <= (state_nx != IDLE);
      done     <= done_nx;
    end
  end

  assign song_idx = idx;

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer - directed and random playback checked against a remaining-cycles reference model.
module tb_melody_sequencer;

  localparam int B = 10;
  localparam int G = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic play = 1'b0;
  logic restart = 1'b0;
  logic [19:0] nd [2];
  logic [2:0]  si [2];
  logic        bz [2];
  logic        dn [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  melody_sequencer #(.BEAT_CYCLES(B), .GAP_CYCLES(G), .LOOP(0)) dut0 (
    .clk(clk), .rst(rst), .play(play), .restart(restart),
    .note_div(nd[0]), .song_idx(si[0]), .busy(bz[0]), .done(dn[0]));

  melody_sequencer #(.BEAT_CYCLES(B), .GAP_CYCLES(G), .LOOP(1)) dut1 (
    .clk(clk), .rst(rst), .play(play), .restart(restart),
    .note_div(nd[1]), .song_idx(si[1]), .busy(bz[1]), .done(dn[1]));

  // Reference: phase 0=idle 1=note 2=gap, with cycles remaining in the phase.
  int tones [8] = '{191571, 170648, 151515, 143266, 127551, 113636, 0, 95420};
  int durs  [8] = '{1, 1, 1, 1, 2, 2, 1, 3};
  int m_ph [2];
  int m_idx [2];
  int m_rem [2];
  bit m_hold [2];
  int e_div [2];
  bit e_done [2];
  int cnt4;
  int ndone;

  function automatic int note_len(input int i);
    return durs[i] * B - G;
  endfunction

  task automatic model(input int k);
    e_done[k] = 1'b0;
    if (rst) begin
      m_ph[k] = 0; m_idx[k] = 0; m_rem[k] = 0; m_hold[k] = 1'b0;
    end else if (restart) begin
      m_idx[k] = 0; m_hold[k] = 1'b0;
      m_ph[k] = play ? 1 : 0;
      m_rem[k] = note_len(0);
    end else if (m_ph[k] == 0) begin
      if (!play) m_hold[k] = 1'b0;
      else if (!m_hold[k]) begin
        m_ph[k] = 1; m_idx[k] = 0; m_rem[k] = note_len(0);
      end
    end else if (play) begin
      if (m_rem[k] > 1) m_rem[k]--;
      else if (m_ph[k] == 1) begin
        m_ph[k] = 2; m_rem[k] = G;
      end else if (m_idx[k] < 7) begin
        m_idx[k]++; m_ph[k] = 1; m_rem[k] = note_len(m_idx[k]);
      end else begin
        m_idx[k] = 0;
        if (k == 1) begin
          m_ph[k] = 1; m_rem[k] = note_len(0);
        end else begin
          m_ph[k] = 0; e_done[k] = 1'b1; m_hold[k] = 1'b1;
        end
      end
    end
    e_div[k] = (!rst && play && m_ph[k] == 1) ? tones[m_idx[k]] : 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    model(0);
    model(1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("note_div[%0d]", k), 32'(nd[k]), 32'(e_div[k]));
      chk($sformatf("song_idx[%0d]", k), 32'(si[k]), 32'(m_idx[k]));
      chk($sformatf("busy[%0d]", k), 32'(bz[k]), 32'(m_ph[k] != 0));
      chk($sformatf("done[%0d]", k), 32'(dn[k]), 32'(e_done[k]));
    end
    if (nd[0] == 20'd127551) cnt4++;
    if (dn[0]) begin
      ndone++;
      chk("loop_wrap_idx", 32'(si[1]), 32'd0);
      chk("loop_wrap_div", 32'(nd[1]), 32'd191571);
    end
  endtask

  initial begin
    int n;
    cnt4 = 0;
    ndone = 0;

    // Reset
    step();
    step();
    rst = 1'b0;

    // Start: first note one cycle after play
    play = 1'b1;
    step();
    chk("first_note", 32'(nd[0]), 32'd191571);
    for (int i = 0; i < 7; i++) step();
    chk("first_note_last", 32'(nd[0]), 32'd191571);
    step();
    chk("gap_silent", 32'(nd[0]), 32'd0);

    // Pause in the middle of entry 4 NOTE
    for (n = 0; n < 200 && !(m_idx[0] == 4 && m_ph[0] == 1); n++) step();
    chk("reach_entry4", 32'(m_idx[0] == 4 && m_ph[0] == 1), 32'd1);
    for (int i = 0; i < 4; i++) step();
    play = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("pause_idx", 32'(si[0]), 32'd4);
      chk("pause_div", 32'(nd[0]), 32'd0);
    end
    play = 1'b1;

    // Run through to the end of the non-looping song
    for (n = 0; n < 300 && ndone == 0; n++) step();
    chk("done_seen", 32'(ndone), 32'd1);
    for (int i = 0; i < 10; i++) step();
    chk("done_once", 32'(ndone), 32'd1);
    chk("entry4_len", 32'(cnt4), 32'd18);
    chk("stopped_busy", 32'(bz[0]), 32'd0);
    chk("stopped_div", 32'(nd[0]), 32'd0);

    // Restart during entry 5 with play high, then with play low
    for (n = 0; n < 300 && m_idx[1] != 5; n++) step();
    chk("reach_entry5a", 32'(m_idx[1]), 32'd5);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("restart_idx", 32'(si[1]), 32'd0);
    chk("restart_div", 32'(nd[1]), 32'd191571);
    for (n = 0; n < 300 && m_idx[1] != 5; n++) step();
    chk("reach_entry5b", 32'(m_idx[1]), 32'd5);
    play = 1'b0;
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("restart_idle_busy", 32'(bz[1]), 32'd0);

    // Reset in the middle of a gap
    play = 1'b1;
    for (n = 0; n < 100 && m_ph[1] != 2; n++) step();
    chk("reach_gap", 32'(m_ph[1]), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    play = 1'b0;
    chk("rst_div", 32'(nd[1]), 32'd0);
    chk("rst_busy", 32'(bz[1]), 32'd0);
    chk("rst_idx", 32'(si[1]), 32'd0);

    // Random play/restart/reset traffic
    for (int i = 0; i < 3000; i++) begin
      play    = ($urandom % 8) != 0;
      restart = ($urandom % 60) == 0;
      rst     = ($urandom % 250) == 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
